cci_mpf_rd_arb: RTL

- Shares one MPF/CCI-P channel-0 read-request port among N_REQ independent requesters inside the AFU.
- Arbitrates round-robin and honours c0TxAlmFull back-pressure.
- Enforces a per-requester outstanding-read credit limit.
- Encodes the requester ID into Mdata and steers read responses back to the originating requester.
- Sits between the AFU engines and the MPF "afu" interface; MPF runs with SORT_READ_RESPONSES=1, so per-requester responses arrive in request order.

---
 rtl/cci_mpf_rd_arb.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cci_mpf_rd_arb.sv
// Round-robin arbiter sharing one MPF channel-0 read port among N_REQ requesters,
// with per-requester credits and response steering. Optional stats: CCI_MPF_RD_ARB_STATS_EN.
module cci_mpf_rd_arb #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 42,
  parameter int TAG_W   = 12,
  parameter int MAX_OUT = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  output logic [N_REQ-1:0]        req_grant,
  input  logic                    c0_almfull,
  output logic                    c0_req_valid,
  output logic [ADDR_W-1:0]       c0_req_addr,
  output logic [15:0]             c0_req_mdata,
  input  logic                    c0_rsp_valid,
  input  logic [15:0]             c0_rsp_mdata,
  input  logic [511:0]            c0_rsp_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [511:0]            rsp_data,
  output logic                    err_sticky
`ifdef CCI_MPF_RD_ARB_STATS_EN
  ,
  input  logic [$clog2(N_REQ):0]  stat_sel,
  output logic [31:0]             stat_value
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int HI_W  = 16 - TAG_W;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]             ptr_q, ptr_d;
  logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0]            elig, grant, rsp_dec;
  logic [ID_W-1:0]             gidx;
  logic                        accept, rsp_legal;
  logic [ADDR_W-1:0]           addr_sel;
  logic [TAG_W-1:0]            tag_sel;
  logic [HI_W-1:0]             rsp_id_hi;

  logic                        c0_req_valid_q, c0_req_valid_d;
  logic [ADDR_W-1:0]           c0_req_addr_q, c0_req_addr_d;
  logic [15:0]                 c0_req_mdata_q, c0_req_mdata_d;
  logic [N_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [TAG_W-1:0]            rsp_tag_q, rsp_tag_d;
  logic [511:0]                rsp_data_q, rsp_data_d;
  logic                        err_q, err_d;

  // Stage 0: eligibility, rotating-priority grant and request mux
  always_comb begin
    grant    = '0;
    gidx     = '0;
    accept   = 1'b0;
    addr_sel = '0;
    tag_sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT)) && !c0_almfull && !reset;
    end
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!accept && elig[i] &&
            ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + N_REQ))) begin
          grant[i] = 1'b1;
          gidx     = ID_W'(i);
          accept   = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        addr_sel = req_addr[i*ADDR_W +: ADDR_W];
        tag_sel  = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Everything above the tag is the ID field; nonzero pad bits read as an out-of-range ID.
  always_comb begin
    rsp_id_hi = c0_rsp_mdata[15:TAG_W];
    for (int i = 0; i < N_REQ; i++) begin
      rsp_dec[i] = c0_rsp_valid && (rsp_id_hi == HI_W'(i)) && (cnt_q[i] != '0);
    end
    rsp_legal = |rsp_dec;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !rsp_dec[i])      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!grant[i] && rsp_dec[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
    c0_req_valid_d = accept;
    c0_req_addr_d  = accept ? addr_sel : '0;
    c0_req_mdata_d = '0;
    if (accept) begin
      c0_req_mdata_d[TAG_W-1:0]    = tag_sel;
      c0_req_mdata_d[TAG_W +: ID_W] = gidx;
    end
    rsp_valid_d = rsp_dec;
    rsp_tag_d   = rsp_legal ? c0_rsp_mdata[TAG_W-1:0] : rsp_tag_q;
    rsp_data_d  = rsp_legal ? c0_rsp_data : rsp_data_q;
    err_d       = err_q | (c0_rsp_valid && !rsp_legal);
  end

  // Stage 1: registered request, response and control state
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q          <= '0;
      cnt_q          <= '0;
      c0_req_valid_q <= 1'b0;
      c0_req_addr_q  <= '0;
      c0_req_mdata_q <= '0;
      rsp_valid_q    <= '0;
      rsp_tag_q      <= '0;
      rsp_data_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      c0_req_valid_q <= c0_req_valid_d;
      c0_req_addr_q  <= c0_req_addr_d;
      c0_req_mdata_q <= c0_req_mdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_tag_q      <= rsp_tag_d;
      rsp_data_q     <= rsp_data_d;
      err_q          <= err_d;
    end
  end

  assign req_grant    = grant;
  assign c0_req_valid = c0_req_valid_q;
  assign c0_req_addr  = c0_req_addr_q;
  assign c0_req_mdata = c0_req_mdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_data     = rsp_data_q;
  assign err_sticky   = err_q;

`ifdef CCI_MPF_RD_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] gnt_cnt_q, gnt_cnt_d, stv_cnt_q, stv_cnt_d;
  logic [31:0]            afl_cnt_q, afl_cnt_d, stat_value_q, stat_value_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      gnt_cnt_d[i] = grant[i] ? sat_inc(gnt_cnt_q[i]) : gnt_cnt_q[i];
      stv_cnt_d[i] = (req_valid[i] && !grant[i]) ? sat_inc(stv_cnt_q[i]) : stv_cnt_q[i];
    end
    afl_cnt_d    = (c0_almfull && |req_valid) ? sat_inc(afl_cnt_q) : afl_cnt_q;
    stat_value_d = '0;
    if (stat_sel == '1) begin
      stat_value_d = afl_cnt_q;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (stat_sel[ID_W-1:0] == ID_W'(i))
          stat_value_d = stat_sel[ID_W] ? stv_cnt_q[i] : gnt_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt_q    <= '0;
      stv_cnt_q    <= '0;
      afl_cnt_q    <= '0;
      stat_value_q <= '0;
    end else begin
      gnt_cnt_q    <= gnt_cnt_d;
      stv_cnt_q    <= stv_cnt_d;
      afl_cnt_q    <= afl_cnt_d;
      stat_value_q <= stat_value_d;
    end
  end

  assign stat_value = stat_value_q;
`endif

endmodule
